// File: rtl/data_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_responder_pkg
//   Definitions shared between the memory responder and the core's decoder.
//   The store-size encodings and FSM state codes live here so that both sides
//   compile against one source and cannot drift apart.
// -----------------------------------------------------------------------------
package data_memory_responder_pkg;

    // Store size on the 'write' port.
    localparam logic [1:0] MEM_WR_NONE = 2'b00;
    localparam logic [1:0] MEM_WR_BYTE = 2'b01;
    localparam logic [1:0] MEM_WR_HALF = 2'b10;
    localparam logic [1:0] MEM_WR_WORD = 2'b11;

    // Store sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Offset of the last byte of a store relative to its start address
    // (bytes - 1).
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            MEM_WR_HALF: return 2'd1;
            MEM_WR_WORD: return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_responder_byte_bank.sv
// -----------------------------------------------------------------------------
// byte_bank
//   One byte-wide RAM bank: synchronous write, registered read.
//   A read of a row written on the same edge returns the old contents.
// Ports
//   clk        system clock
//   i_rd_row   read row, sampled every rising edge
//   o_rd_data  registered read data
//   i_we       write enable
//   i_wr_row   write row
//   i_wr_data  write data
// -----------------------------------------------------------------------------
module byte_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_rd_row,
    output logic [7:0]            o_rd_data,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_row,
    input  logic [7:0]            i_wr_data
);

    logic [7:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // survive a reset of the surrounding logic.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_row];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//   Memory-side responder for the multicycle core's byte-lane port.
//   Four byte banks (bank = byte address[1:0]) return four consecutive bytes
//   at any byte address one cycle after the address is presented. Stores are
//   serialised one byte per clock; done pulses when a store completes or is
//   rejected, and error latches any misaligned or out-of-range store.
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   address  byte address of the access
//   write    store size: 00 none, 01 byte, 10 half, 11 word
//   d0..d3   store lanes, dK goes to byte address+(3-K)
//   q0..q3   load lanes, qK = byte at address+(3-K), one cycle later
//   done     one-cycle pulse at store completion or rejection
//   error    sticky flag for a rejected store
// -----------------------------------------------------------------------------
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [1:0]  write,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    input  logic [7:0]  d2,
    input  logic [7:0]  d3,
    output logic [7:0]  q0,
    output logic [7:0]  q1,
    output logic [7:0]  q2,
    output logic [7:0]  q3,
    output logic        done,
    output logic        error
);

    localparam int unsigned LP_OFF_W     = ADDR_WIDTH + 2;
    localparam logic [32:0] LP_MEM_BYTES = 33'd1 << LP_OFF_W;

    // Store sequencer and holding registers.
    state_t              r_state;
    logic [1:0]          r_cnt;
    logic [1:0]          r_last;
    logic [LP_OFF_W-1:0] r_addr;
    logic [7:0]          r_wbyte [4];   // indexed by byte offset from r_addr
    logic                r_done;
    logic                r_error;

    // Read-side registers: lane rotation and per-lane out-of-range kill.
    logic [1:0]          r_rot;
    logic [3:0]          r_kill;

    logic [7:0]          w_bank_q [4];
    logic [7:0]          w_q [4];
    logic [3:0]          w_lane_oor;
    logic [3:0]          w_we;
    logic [LP_OFF_W-1:0] w_wr_off;
    logic [32:0]         w_last_byte;
    logic                w_misaligned;
    logic                w_bad_store;

    // Byte currently being stored; a store that passed the range check
    // cannot carry past the top of memory, so LP_OFF_W bits are enough.
    assign w_wr_off = r_addr + LP_OFF_W'(r_cnt);

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [ADDR_WIDTH-1:0] w_rd_row;

        // Bank b supplies the lane whose byte address ends in b. When that
        // byte lies below address[1:0] in bank order it belongs to the next
        // word, so the row steps by one.
        assign w_rd_row = address[LP_OFF_W-1:2] + ADDR_WIDTH'(2'(b) < address[1:0]);
        assign w_we[b]  = (r_state == ST_WRITE) && (w_wr_off[1:0] == 2'(b));

        byte_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
            .clk       (clk),
            .i_rd_row  (w_rd_row),
            .o_rd_data (w_bank_q[b]),
            .i_we      (w_we[b]),
            .i_wr_row  (w_wr_off[LP_OFF_W-1:2]),
            .i_wr_data (r_wbyte[r_cnt])
        );
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        // 33-bit sum so a wrap past 2^32 also lands out of range.
        assign w_lane_oor[k] = ({1'b0, address} + 33'(3 - k)) >= LP_MEM_BYTES;
        assign w_q[k]        = r_kill[k] ? 8'h00 : w_bank_q[r_rot + 2'(3 - k)];
    end

    assign q0    = w_q[0];
    assign q1    = w_q[1];
    assign q2    = w_q[2];
    assign q3    = w_q[3];
    assign done  = r_done;
    assign error = r_error;

    assign w_last_byte  = {1'b0, address} + {31'd0, last_index(write)};
    assign w_misaligned = ((write == MEM_WR_HALF) && address[0]) ||
                          ((write == MEM_WR_WORD) && (address[1:0] != 2'b00));
    assign w_bad_store  = w_misaligned || (w_last_byte >= LP_MEM_BYTES);

    // The kill mask resets to all ones, which holds q at zero through reset
    // without having to clear the RAM outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rot  <= 2'b00;
            r_kill <= 4'hF;
        end else begin
            r_rot  <= address[1:0];
            r_kill <= w_lane_oor;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_last  <= 2'd0;
            r_addr  <= '0;
            r_wbyte <= '{default: 8'h00};
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (write != MEM_WR_NONE) begin
                        r_addr     <= address[LP_OFF_W-1:0];
                        r_wbyte[0] <= d3;
                        r_wbyte[1] <= d2;
                        r_wbyte[2] <= d1;
                        r_wbyte[3] <= d0;
                        r_cnt      <= 2'd0;
                        r_last     <= last_index(write);
                        if (w_bad_store) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == r_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // The core keeps write asserted past done; wait for it to
                    // drop so one request is never stored twice.
                    if (write == MEM_WR_NONE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//   Directed scenarios with literal expectations, then randomized traffic.
//   A transaction-level model (byte array, scheduled byte writes, done cycle)
//   predicts q/done/error for every cycle and one process compares them.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

    localparam int ADDR_WIDTH = 10;
    localparam int MEM_BYTES  = 4 * (1 << ADDR_WIDTH);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [1:0]  write;
    logic [7:0]  d0, d1, d2, d3;
    logic [7:0]  q0, q1, q2, q3;
    logic        done;
    logic        error;

    data_memory_responder #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .write   (write),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .q0      (q0),
        .q1      (q1),
        .q2      (q2),
        .q3      (q3),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int         edge_c;   // cycle whose closing edge stores the byte
        int         addr;
        logic [7:0] data;
    } wr_t;

    logic [7:0] m_mem   [MEM_BYTES];
    bit         m_known [MEM_BYTES];
    wr_t        m_pend  [$];
    bit         m_idle;
    int         m_done_at;
    bit         m_error;
    int         cyc = 0;

    logic [7:0] e_q     [4];
    bit         e_known [4];
    bit         e_done;

    logic [7:0] qa [4];
    assign qa[0] = q0;
    assign qa[1] = q1;
    assign qa[2] = q2;
    assign qa[3] = q3;

    function automatic logic [7:0] lane_in(input int j);
        case (j)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_idle    = 1'b1;
        m_done_at = -100;
        m_error   = 1'b0;
        e_done    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e_q[k]     = 8'h00;
            e_known[k] = 1'b1;
        end
    endtask

    // Called at a rising edge with the inputs of cycle 'cyc'; produces the
    // expected outputs for cycle cyc+1.
    task automatic model_step();
        longint a;
        int     nb;
        bit     bad;
        a = longint'({32'd0, address});
        // Loads see memory as it was before this edge's store.
        for (int k = 0; k < 4; k++) begin
            longint ba;
            ba = a + longint'(3 - k);
            if (ba >= MEM_BYTES) begin
                e_q[k]     = 8'h00;
                e_known[k] = 1'b1;
            end else begin
                e_q[k]     = m_mem[int'(ba)];
                e_known[k] = m_known[int'(ba)];
            end
        end
        while (m_pend.size() > 0 && m_pend[0].edge_c == cyc) begin
            m_mem[m_pend[0].addr]   = m_pend[0].data;
            m_known[m_pend[0].addr] = 1'b1;
            void'(m_pend.pop_front());
        end
        if (m_idle && write != 2'b00) begin
            nb  = (write == 2'b01) ? 1 : (write == 2'b10) ? 2 : 4;
            bad = (nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0) ||
                  (a + longint'(nb - 1) >= MEM_BYTES);
            m_idle = 1'b0;
            if (bad) begin
                m_error   = 1'b1;
                m_done_at = cyc + 1;
            end else begin
                for (int i = 0; i < nb; i++)
                    m_pend.push_back('{cyc + 1 + i, int'(a) + i, lane_in(3 - i)});
                m_done_at = cyc + nb + 1;
            end
        end else if (!m_idle && cyc > m_done_at && write == 2'b00) begin
            m_idle = 1'b1;
        end
        e_done = (m_done_at == cyc + 1);
    endtask

    initial begin : compare_proc
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else      model_step();
            cyc++;
            @(negedge clk);
            if (!rst) model_reset();
            for (int k = 0; k < 4; k++)
                if (e_known[k])
                    check($sformatf("q%0d_cyc%0d", k, cyc), 32'(qa[k]), 32'(e_q[k]));
            check($sformatf("done_cyc%0d", cyc), 32'(done), 32'(e_done));
            check($sformatf("error_cyc%0d", cyc), 32'(error), 32'(m_error));
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    // Presents a store in cycle N, keeps write asserted for 'hold' cycles,
    // then reports the first cycle offset i (cycle N+i) with done high and
    // the number of done pulses seen over a fixed window.
    task automatic do_store(input logic [31:0] a, input logic [1:0] s,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int hold, output int done_cyc, output int n_done);
        @(posedge clk); #1;
        address = a; write = s; d0 = b0; d1 = b1; d2 = b2; d3 = b3;
        done_cyc = -1;
        n_done   = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == hold) write = 2'b00;
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = i;
            end
        end
        write = 2'b00;
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] v);
        @(posedge clk); #1;
        address = a; write = 2'b00;
        @(posedge clk);
        @(negedge clk);
        v = {q0, q1, q2, q3};
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int          dc, nd, r;
        logic [31:0] v;

        rst = 1'b0; address = '0; write = 2'b00;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_q",     {q0, q1, q2, q3}, 32'h0);
        check("reset_done",  32'(done),  32'h0);
        check("reset_error", 32'(error), 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Word store, then aligned read.
        do_store(32'h10, 2'b11, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1, dc, nd);
        check("word_done_cycle", 32'(dc), 32'd5);
        check("word_done_count", 32'(nd), 32'd1);
        read_word(32'h10, v);
        check("word_readback", v, 32'hDEADBEEF);
        check("word_error", 32'(error), 32'h0);

        // Mid-word read crossing into the next row.
        do_store(32'h14, 2'b11, 8'h44, 8'h33, 8'h22, 8'h11, 1, dc, nd);
        read_word(32'h12, v);
        check("cross_read", v, 32'h2211DEAD);

        // Byte and half stores into a known word.
        do_store(32'h20, 2'b11, 8'h99, 8'h88, 8'h77, 8'h66, 1, dc, nd);
        do_store(32'h21, 2'b01, 8'h00, 8'h00, 8'h00, 8'h5A, 1, dc, nd);
        check("byte_done_cycle", 32'(dc), 32'd2);
        do_store(32'h22, 2'b10, 8'h00, 8'h00, 8'h12, 8'h34, 1, dc, nd);
        check("half_done_cycle", 32'(dc), 32'd3);
        read_word(32'h20, v);
        check("byte_half_read", v, 32'h12345A66);

        // Misaligned half store is rejected.
        do_store(32'h13, 2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF, 1, dc, nd);
        check("misalign_done_cycle", 32'(dc), 32'd1);
        check("misalign_done_count", 32'(nd), 32'd1);
        check("misalign_error", 32'(error), 32'h1);
        read_word(32'h12, v);
        check("misalign_no_write", v, 32'h2211DEAD);
        do_store(32'h30, 2'b01, 8'h00, 8'h00, 8'h00, 8'h77, 1, dc, nd);
        check("error_sticky", 32'(error), 32'h1);

        // write held six cycles past done: one store, one pulse.
        do_store(32'h40, 2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 12, dc, nd);
        check("hold_done_cycle", 32'(dc), 32'd5);
        check("hold_done_count", 32'(nd), 32'd1);
        do_store(32'h44, 2'b01, 8'h00, 8'h00, 8'h00, 8'h55, 1, dc, nd);
        check("after_hold_done_cycle", 32'(dc), 32'd2);
        read_word(32'h40, v);
        check("hold_readback", v, 32'h01020304);

        // Reset after two bytes of a word store.
        do_store(32'h50, 2'b11, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, dc, nd);
        @(posedge clk); #1;
        address = 32'h50; write = 2'b11;
        d0 = 8'hB0; d1 = 8'hB1; d2 = 8'hB2; d3 = 8'hB3;
        @(posedge clk); #1 write = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_pre_done", 32'(done), 32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_q",     {q0, q1, q2, q3}, 32'h0);
        check("rst_mid_done",  32'(done),  32'h0);
        check("rst_mid_error", 32'(error), 32'h0);
        #1 rst = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("rst_mid_no_done", 32'(nd), 32'd0);
        read_word(32'h50, v);
        check("rst_mid_partial", v, 32'hA0A1B2B3);

        // Top of memory.
        do_store(32'hFFC, 2'b11, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1, dc, nd);
        check("top_word_done_cycle", 32'(dc), 32'd5);
        do_store(32'hFFE, 2'b11, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1, dc, nd);
        check("oor_done_cycle", 32'(dc), 32'd1);
        check("oor_error", 32'(error), 32'h1);
        read_word(32'hFFE, v);
        check("oor_read_edge", v, 32'h0000C0C1);
        read_word(32'hFFFF_FFFE, v);
        check("oor_read_wrap", v, 32'h0);
        read_word(32'h1000, v);
        check("oor_read_end", v, 32'h0);

        // Randomized traffic checked by the model.
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            r = int'($urandom_range(0, 99));
            if (r < 70)      address = $urandom_range(0, MEM_BYTES - 1);
            else if (r < 90) address = $urandom_range(MEM_BYTES - 16, MEM_BYTES + 4);
            else if (r < 95) address = 32'hFFFF_FFFF - $urandom_range(0, 4);
            else             address = $urandom;
            write = ($urandom_range(0, 99) < 35) ? 2'($urandom_range(1, 3)) : 2'b00;
            d0 = 8'($urandom); d1 = 8'($urandom);
            d2 = 8'($urandom); d3 = 8'($urandom);
            rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
        end

        @(posedge clk); #1;
        write = 2'b00; rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
